// File: rtl/mi_issue_ctrl.sv
// mi_issue_ctrl: NUM_LANES in-order issue control: load-use scoreboard, issue-mode FSM, lane kills.
// Optional saturating perf counters are built when MI_ISSUE_CTRL_PERF_EN is defined.
module mi_issue_ctrl #(
  parameter int unsigned NUM_LANES  = 2,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned LOAD_LAT   = 1,
  parameter int unsigned COOLDOWN   = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_LANES-1:0]            lane_valid_i,
  input  logic [NUM_LANES*REG_ADDR_W-1:0] lane_rs1_i,
  input  logic [NUM_LANES*REG_ADDR_W-1:0] lane_rs2_i,
  input  logic [NUM_LANES-1:0]            lane_rs1_used_i,
  input  logic [NUM_LANES-1:0]            lane_rs2_used_i,
  input  logic [NUM_LANES-1:0]            load_issue_i,
  input  logic [NUM_LANES*REG_ADDR_W-1:0] load_rd_i,
  input  logic                            pi_id_ready_i,
  input  logic                            pi_ex_ready_i,
  input  logic                            pi_branch_taken_ex_i,
  input  logic                            pi_data_misaligned_i,
  input  logic                            pi_halt_id_i,
  input  logic                            pi_unusual_prevent_i,
  input  logic                            pi_unusual_kill_i,
  output logic [NUM_LANES-1:0]            lane_issue_en_o,
  output logic [NUM_LANES-1:0]            lane_stall_o,
  output logic [NUM_LANES-1:0]            lane_kill_o,
  output logic                            load_stall_o,
  output logic [1:0]                      mode_o,
  output logic [31:0]                     perf_stall_cnt_o,
  output logic [15:0]                     perf_kill_cnt_o
);

  localparam int unsigned CNT_W = 4;
  localparam logic [NUM_LANES-1:0] YOUNGER_MASK = ~NUM_LANES'(1);

  typedef enum logic [1:0] {
    ST_MULTI  = 2'b00,
    ST_SINGLE = 2'b01,
    ST_COOL   = 2'b10
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic                  r_sb_v  [NUM_LANES][LOAD_LAT];
  logic [REG_ADDR_W-1:0] r_sb_rd [NUM_LANES][LOAD_LAT];

  logic                  w_advance;
  logic                  w_multi_ok;
  logic [NUM_LANES-1:0]  w_hazard;
  logic [NUM_LANES-1:0]  w_stall;
  logic [NUM_LANES-1:0]  w_kill;
  logic [NUM_LANES-1:0]  w_issue_en;
  logic [NUM_LANES-1:0]  w_insert;

  assign w_advance  = pi_ex_ready_i & ~pi_data_misaligned_i;
  assign w_multi_ok = (r_state == ST_MULTI) & ~pi_unusual_prevent_i &
                      ~pi_data_misaligned_i & ~pi_halt_id_i;

  // Per-lane hazard: any used source matches any valid in-flight load of any lane.
  always_comb begin
    logic hit;
    w_hazard = '0;
    for (int unsigned k = 0; k < NUM_LANES; k++) begin
      hit = 1'b0;
      for (int unsigned j = 0; j < NUM_LANES; j++) begin
        for (int unsigned a = 0; a < LOAD_LAT; a++) begin
          if (r_sb_v[j][a]) begin
            if (lane_rs1_used_i[k] &&
                (lane_rs1_i[k*REG_ADDR_W +: REG_ADDR_W] == r_sb_rd[j][a])) begin
              hit = 1'b1;
            end
            if (lane_rs2_used_i[k] &&
                (lane_rs2_i[k*REG_ADDR_W +: REG_ADDR_W] == r_sb_rd[j][a])) begin
              hit = 1'b1;
            end
          end
        end
      end
      w_hazard[k] = hit & lane_valid_i[k];
    end
  end

  // In-order stall: a stalled lane holds back every younger lane.
  always_comb begin
    logic acc;
    acc     = 1'b0;
    w_stall = '0;
    for (int unsigned k = 0; k < NUM_LANES; k++) begin
      acc        = acc | w_hazard[k];
      w_stall[k] = acc;
    end
  end

  always_comb begin
    w_issue_en    = {NUM_LANES{w_multi_ok}};
    w_issue_en[0] = ~pi_halt_id_i;
  end

  assign w_kill = {NUM_LANES{pi_branch_taken_ex_i}} |
                  ({NUM_LANES{pi_unusual_kill_i}} & YOUNGER_MASK);

  always_comb begin
    w_insert = '0;
    for (int unsigned k = 0; k < NUM_LANES; k++) begin
      w_insert[k] = w_advance & pi_id_ready_i & lane_valid_i[k] & load_issue_i[k] &
                    w_issue_en[k] & ~w_stall[k] & ~w_kill[k] &
                    (load_rd_i[k*REG_ADDR_W +: REG_ADDR_W] != '0);
    end
  end

  // Scoreboard ages only on advancing cycles; the oldest age falls off the end.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < NUM_LANES; k++) begin
        for (int unsigned a = 0; a < LOAD_LAT; a++) begin
          r_sb_v[k][a]  <= 1'b0;
          r_sb_rd[k][a] <= '0;
        end
      end
    end else if (w_advance) begin
      for (int unsigned k = 0; k < NUM_LANES; k++) begin
        for (int unsigned a = LOAD_LAT - 1; a > 0; a--) begin
          r_sb_v[k][a]  <= r_sb_v[k][a-1];
          r_sb_rd[k][a] <= r_sb_rd[k][a-1];
        end
        r_sb_v[k][0]  <= w_insert[k];
        r_sb_rd[k][0] <= load_rd_i[k*REG_ADDR_W +: REG_ADDR_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_MULTI;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Issue mode; a kill overrides everything and (re)starts the cooldown window.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (pi_unusual_kill_i) begin
      w_state_nxt = ST_COOL;
      w_cnt_nxt   = CNT_W'(COOLDOWN - 1);
    end else begin
      case (r_state)
        ST_MULTI: begin
          if (pi_unusual_prevent_i) w_state_nxt = ST_SINGLE;
        end
        ST_SINGLE: begin
          if (!pi_unusual_prevent_i) w_state_nxt = ST_MULTI;
        end
        ST_COOL: begin
          if (!pi_halt_id_i) begin
            if (r_cnt == '0) begin
              w_state_nxt = pi_unusual_prevent_i ? ST_SINGLE : ST_MULTI;
            end else begin
              w_cnt_nxt = r_cnt - CNT_W'(1);
            end
          end
        end
        default: w_state_nxt = ST_MULTI;
      endcase
    end
  end

  assign lane_issue_en_o = rst ? '0 : w_issue_en;
  assign lane_stall_o    = rst ? '0 : w_stall;
  assign lane_kill_o     = rst ? '0 : w_kill;
  assign load_stall_o    = rst ? 1'b0 : w_stall[0];
  assign mode_o          = rst ? 2'b00 : r_state;

`ifdef MI_ISSUE_CTRL_PERF_EN
  logic [31:0] r_perf_stall;
  logic [15:0] r_perf_kill;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_stall <= '0;
      r_perf_kill  <= '0;
    end else begin
      if ((|w_stall) && (r_perf_stall != '1)) r_perf_stall <= r_perf_stall + 32'd1;
      if ((pi_unusual_kill_i | pi_branch_taken_ex_i) && (r_perf_kill != '1)) begin
        r_perf_kill <= r_perf_kill + 16'd1;
      end
    end
  end

  assign perf_stall_cnt_o = r_perf_stall;
  assign perf_kill_cnt_o  = r_perf_kill;
`else
  assign perf_stall_cnt_o = '0;
  assign perf_kill_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_mi_issue_ctrl.sv
// Bench for mi_issue_ctrl: two instances (LOAD_LAT=1 and LOAD_LAT=2) share one stimulus table.
module tb_mi_issue_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  lane_valid_i, lane_rs1_used_i, lane_rs2_used_i, load_issue_i;
  logic [9:0]  lane_rs1_i, lane_rs2_i, load_rd_i;
  logic        pi_id_ready_i, pi_ex_ready_i, pi_branch_taken_ex_i, pi_data_misaligned_i;
  logic        pi_halt_id_i, pi_unusual_prevent_i, pi_unusual_kill_i;

  logic [1:0]  d1_en, d1_stall, d1_kill, d1_mode, d2_en, d2_stall, d2_kill, d2_mode;
  logic        d1_ls, d2_ls;
  logic [31:0] d1_ps, d2_ps;
  logic [15:0] d1_pk, d2_pk;

  mi_issue_ctrl #(.NUM_LANES(2), .REG_ADDR_W(5), .LOAD_LAT(1), .COOLDOWN(4)) u_dut1 (
    .clk(clk), .rst(rst), .lane_valid_i(lane_valid_i), .lane_rs1_i(lane_rs1_i),
    .lane_rs2_i(lane_rs2_i), .lane_rs1_used_i(lane_rs1_used_i), .lane_rs2_used_i(lane_rs2_used_i),
    .load_issue_i(load_issue_i), .load_rd_i(load_rd_i), .pi_id_ready_i(pi_id_ready_i),
    .pi_ex_ready_i(pi_ex_ready_i), .pi_branch_taken_ex_i(pi_branch_taken_ex_i),
    .pi_data_misaligned_i(pi_data_misaligned_i), .pi_halt_id_i(pi_halt_id_i),
    .pi_unusual_prevent_i(pi_unusual_prevent_i), .pi_unusual_kill_i(pi_unusual_kill_i),
    .lane_issue_en_o(d1_en), .lane_stall_o(d1_stall), .lane_kill_o(d1_kill),
    .load_stall_o(d1_ls), .mode_o(d1_mode), .perf_stall_cnt_o(d1_ps), .perf_kill_cnt_o(d1_pk));

  mi_issue_ctrl #(.NUM_LANES(2), .REG_ADDR_W(5), .LOAD_LAT(2), .COOLDOWN(4)) u_dut2 (
    .clk(clk), .rst(rst), .lane_valid_i(lane_valid_i), .lane_rs1_i(lane_rs1_i),
    .lane_rs2_i(lane_rs2_i), .lane_rs1_used_i(lane_rs1_used_i), .lane_rs2_used_i(lane_rs2_used_i),
    .load_issue_i(load_issue_i), .load_rd_i(load_rd_i), .pi_id_ready_i(pi_id_ready_i),
    .pi_ex_ready_i(pi_ex_ready_i), .pi_branch_taken_ex_i(pi_branch_taken_ex_i),
    .pi_data_misaligned_i(pi_data_misaligned_i), .pi_halt_id_i(pi_halt_id_i),
    .pi_unusual_prevent_i(pi_unusual_prevent_i), .pi_unusual_kill_i(pi_unusual_kill_i),
    .lane_issue_en_o(d2_en), .lane_stall_o(d2_stall), .lane_kill_o(d2_kill),
    .load_stall_o(d2_ls), .mode_o(d2_mode), .perf_stall_cnt_o(d2_ps), .perf_kill_cnt_o(d2_pk));

  // ctl bits: {id_ready, ex_ready, branch, misaligned, halt, prevent, kill}
  localparam logic [6:0] C_ID = 7'h40, C_EX = 7'h20, C_BR = 7'h10, C_MIS = 7'h08;
  localparam logic [6:0] C_HALT = 7'h04, C_PREV = 7'h02, C_KILL = 7'h01, NORM = 7'h60;
  localparam logic [1:0] N = 2'b00;
  localparam logic [9:0] Z = 10'd0;

  typedef struct {
    logic       rst;
    logic [1:0] valid;
    logic [9:0] rs1;
    logic [9:0] rs2;
    logic [1:0] u1;
    logic [1:0] u2;
    logic [1:0] ld;
    logic [9:0] ldrd;
    logic [6:0] ctl;
    logic [1:0] st1;
    logic [1:0] st2;
    logic [1:0] kl;
    logic [1:0] en;
    logic [1:0] md;
  } vec_t;

  vec_t tbl[$];
  vec_t hand[$];
  vec_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   row_no = 0;
  int   t_s1 = 0, t_s2 = 0, t_k = 0;

  function automatic vec_t mk(input logic r, input logic [1:0] valid, input logic [9:0] rs1,
                              input logic [9:0] rs2, input logic [1:0] u1, input logic [1:0] u2,
                              input logic [1:0] ld, input logic [9:0] ldrd, input logic [6:0] ctl,
                              input logic [1:0] st1, input logic [1:0] st2, input logic [1:0] kl,
                              input logic [1:0] en, input logic [1:0] md);
    vec_t v;
    v.rst = r;  v.valid = valid; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
    v.ld = ld;  v.ldrd = ldrd;   v.ctl = ctl; v.st1 = st1; v.st2 = st2;
    v.kl = kl;  v.en = en;       v.md = md;
    return v;
  endfunction

  function automatic logic [9:0] r2(input int l1, input int l0);
    return {5'(l1), 5'(l0)};
  endfunction

  task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s row %0d: got %0h expected %0h", nm, row, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    vec_t e;
    @(negedge clk);
    rst = v.rst; lane_valid_i = v.valid; lane_rs1_i = v.rs1; lane_rs2_i = v.rs2;
    lane_rs1_used_i = v.u1; lane_rs2_used_i = v.u2; load_issue_i = v.ld; load_rd_i = v.ldrd;
    {pi_id_ready_i, pi_ex_ready_i, pi_branch_taken_ex_i, pi_data_misaligned_i,
     pi_halt_id_i, pi_unusual_prevent_i, pi_unusual_kill_i} = v.ctl;
    exp_q.push_back(v);
    #2;
    e = exp_q.pop_front();
    chk("stall_lat1", row_no, 32'(d1_stall), 32'(e.st1));
    chk("stall_lat2", row_no, 32'(d2_stall), 32'(e.st2));
    chk("load_stall", row_no, 32'(d1_ls), 32'(e.st1[0]));
    chk("kill",       row_no, 32'({d1_kill, d2_kill}), 32'({e.kl, e.kl}));
    chk("issue_en",   row_no, 32'({d1_en, d2_en}), 32'({e.en, e.en}));
    chk("mode",       row_no, 32'({d1_mode, d2_mode}), 32'({e.md, e.md}));
    if (e.rst) begin
      t_s1 = 0; t_s2 = 0; t_k = 0;
    end else begin
      t_s1 += (e.st1 != 2'b00) ? 1 : 0;
      t_s2 += (e.st2 != 2'b00) ? 1 : 0;
      t_k  += (e.ctl[4] | e.ctl[0]) ? 1 : 0;
    end
    row_no++;
  endtask

  task automatic check_perf(input string nm, input int s1, input int s2, input int k);
    @(posedge clk);
    #1;
`ifdef MI_ISSUE_CTRL_PERF_EN
    chk({nm, "_stall_cnt1"}, row_no, d1_ps, 32'(s1));
    chk({nm, "_stall_cnt2"}, row_no, d2_ps, 32'(s2));
    chk({nm, "_kill_cnt"},   row_no, 32'({d1_pk, d2_pk}), {16'(k), 16'(k)});
`else
    chk({nm, "_stall_cnt1"}, row_no, d1_ps, 32'(s1 * 0));
    chk({nm, "_stall_cnt2"}, row_no, d2_ps, 32'(s2 * 0));
    chk({nm, "_kill_cnt"},   row_no, 32'({d1_pk, d2_pk}), 32'(k * 0));
`endif
  endtask

  initial begin
    rst = 1'b1; lane_valid_i = N; lane_rs1_i = Z; lane_rs2_i = Z; lane_rs1_used_i = N;
    lane_rs2_used_i = N; load_issue_i = N; load_rd_i = Z; pi_id_ready_i = 1'b0;
    pi_ex_ready_i = 1'b0; pi_branch_taken_ex_i = 1'b0; pi_data_misaligned_i = 1'b0;
    pi_halt_id_i = 1'b0; pi_unusual_prevent_i = 1'b0; pi_unusual_kill_i = 1'b0;

    // reset gating
    tbl.push_back(mk(1'b1, 2'b11, r2(5,5), Z, 2'b11, N, 2'b11, r2(5,5), NORM|C_BR|C_KILL, N, N, N, N, N));
    tbl.push_back(mk(1'b1, N, Z, Z, N, N, N, Z, NORM, N, N, N, N, N));
    tbl.push_back(mk(1'b0, N, Z, Z, N, N, N, Z, NORM, N, N, N, 2'b11, N));
    // lane0 loads x5, lane1 reads it
    tbl.push_back(mk(1'b0, 2'b11, Z, Z, N, N, 2'b01, r2(0,5), NORM, N, N, N, 2'b11, N));
    tbl.push_back(mk(1'b0, 2'b11, r2(5,0), Z, 2'b10, N, N, Z, NORM, 2'b10, 2'b10, N, 2'b11, N));
    tbl.push_back(mk(1'b0, 2'b11, r2(5,0), Z, 2'b10, N, N, Z, NORM, N, 2'b10, N, 2'b11, N));
    tbl.push_back(mk(1'b0, 2'b11, r2(5,0), Z, 2'b10, N, N, Z, NORM, N, N, N, 2'b11, N));
    // load x7, then one non-advancing cycle
    tbl.push_back(mk(1'b0, 2'b11, Z, Z, N, N, 2'b01, r2(0,7), NORM, N, N, N, 2'b11, N));
    tbl.push_back(mk(1'b0, 2'b11, r2(7,0), Z, 2'b10, N, N, Z, C_ID, 2'b10, 2'b10, N, 2'b11, N));
    tbl.push_back(mk(1'b0, 2'b11, r2(7,0), Z, 2'b10, N, N, Z, NORM, 2'b10, 2'b10, N, 2'b11, N));
    tbl.push_back(mk(1'b0, 2'b11, r2(7,0), Z, 2'b10, N, N, Z, NORM, N, 2'b10, N, 2'b11, N));
    tbl.push_back(mk(1'b0, 2'b11, r2(7,0), Z, 2'b10, N, N, Z, NORM, N, N, N, 2'b11, N));
    // both lanes load; lane0 hazard stalls lane1 too
    tbl.push_back(mk(1'b0, 2'b11, Z, Z, N, N, 2'b11, r2(10,9), NORM, N, N, N, 2'b11, N));
    tbl.push_back(mk(1'b0, 2'b01, r2(0,10), Z, 2'b01, N, N, Z, NORM, 2'b11, 2'b11, N, 2'b11, N));
    tbl.push_back(mk(1'b0, 2'b01, r2(0,9), Z, 2'b01, N, N, Z, NORM, N, 2'b11, N, 2'b11, N));
    tbl.push_back(mk(1'b0, 2'b01, r2(0,9), Z, 2'b01, N, N, Z, NORM, N, N, N, 2'b11, N));
    // x0 load, unused source, invalid reader
    tbl.push_back(mk(1'b0, 2'b11, Z, Z, N, N, 2'b11, r2(12,0), NORM, N, N, N, 2'b11, N));
    tbl.push_back(mk(1'b0, 2'b11, r2(12,0), Z, 2'b01, N, N, Z, NORM, N, N, N, 2'b11, N));
    tbl.push_back(mk(1'b0, N, r2(12,12), Z, 2'b11, N, N, Z, NORM, N, N, N, 2'b11, N));
    // kill pulse and cooldown
    tbl.push_back(mk(1'b0, N, Z, Z, N, N, N, Z, NORM|C_KILL, N, N, 2'b10, 2'b11, 2'b00));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(1'b0, N, Z, Z, N, N, N, Z, NORM, N, N, N, 2'b01, 2'b10));
    tbl.push_back(mk(1'b0, N, Z, Z, N, N, N, Z, NORM, N, N, N, 2'b11, 2'b00));
    // kill with prevent, a halted cooldown cycle, exit into SINGLE
    tbl.push_back(mk(1'b0, N, Z, Z, N, N, N, Z, NORM|C_KILL|C_PREV, N, N, 2'b10, 2'b01, 2'b00));
    tbl.push_back(mk(1'b0, N, Z, Z, N, N, N, Z, NORM|C_PREV, N, N, N, 2'b01, 2'b10));
    tbl.push_back(mk(1'b0, N, Z, Z, N, N, N, Z, NORM|C_PREV|C_HALT, N, N, N, 2'b00, 2'b10));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1'b0, N, Z, Z, N, N, N, Z, NORM|C_PREV, N, N, N, 2'b01, 2'b10));
    tbl.push_back(mk(1'b0, N, Z, Z, N, N, N, Z, NORM|C_PREV, N, N, N, 2'b01, 2'b01));
    tbl.push_back(mk(1'b0, N, Z, Z, N, N, N, Z, NORM, N, N, N, 2'b01, 2'b01));
    tbl.push_back(mk(1'b0, N, Z, Z, N, N, N, Z, NORM, N, N, N, 2'b11, 2'b00));
    // misaligned: no advance, no insert, single issue
    tbl.push_back(mk(1'b0, 2'b01, Z, Z, N, N, 2'b01, r2(0,17), NORM|C_MIS, N, N, N, 2'b01, 2'b00));
    tbl.push_back(mk(1'b0, 2'b10, r2(17,0), Z, 2'b10, N, N, Z, NORM, N, N, N, 2'b11, 2'b00));
    // kill from SINGLE, then reload during cooldown
    tbl.push_back(mk(1'b0, N, Z, Z, N, N, N, Z, NORM|C_PREV, N, N, N, 2'b01, 2'b00));
    tbl.push_back(mk(1'b0, N, Z, Z, N, N, N, Z, NORM|C_PREV|C_KILL, N, N, 2'b10, 2'b01, 2'b01));
    tbl.push_back(mk(1'b0, N, Z, Z, N, N, N, Z, NORM|C_PREV, N, N, N, 2'b01, 2'b10));
    tbl.push_back(mk(1'b0, N, Z, Z, N, N, N, Z, NORM|C_PREV|C_KILL, N, N, 2'b10, 2'b01, 2'b10));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(1'b0, N, Z, Z, N, N, N, Z, NORM, N, N, N, 2'b01, 2'b10));
    tbl.push_back(mk(1'b0, N, Z, Z, N, N, N, Z, NORM, N, N, N, 2'b11, 2'b00));
    // branch taken squashes the load in ID
    tbl.push_back(mk(1'b0, 2'b01, Z, Z, N, N, 2'b01, r2(0,14), NORM|C_BR, N, N, 2'b11, 2'b11, 2'b00));
    tbl.push_back(mk(1'b0, 2'b10, r2(14,0), Z, 2'b10, N, N, Z, NORM, N, N, N, 2'b11, 2'b00));
    // reset mid-operation clears scoreboard and FSM
    tbl.push_back(mk(1'b0, 2'b01, Z, Z, N, N, 2'b01, r2(0,15), NORM, N, N, N, 2'b11, 2'b00));
    tbl.push_back(mk(1'b1, 2'b10, r2(15,0), Z, 2'b10, N, N, Z, NORM, N, N, N, N, N));
    tbl.push_back(mk(1'b0, 2'b10, r2(15,0), Z, 2'b10, N, N, Z, NORM, N, N, N, 2'b11, 2'b00));
    tbl.push_back(mk(1'b0, N, Z, Z, N, N, N, Z, NORM|C_KILL, N, N, 2'b10, 2'b11, 2'b00));
    tbl.push_back(mk(1'b1, N, Z, Z, N, N, N, Z, NORM, N, N, N, N, N));
    tbl.push_back(mk(1'b0, N, Z, Z, N, N, N, Z, NORM, N, N, N, 2'b11, 2'b00));
    // rs2 hazard from a lane1 load
    tbl.push_back(mk(1'b0, 2'b10, Z, Z, N, N, 2'b10, r2(20,0), NORM, N, N, N, 2'b11, 2'b00));
    tbl.push_back(mk(1'b0, 2'b01, Z, r2(0,20), N, 2'b01, N, Z, NORM, 2'b11, 2'b11, N, 2'b11, 2'b00));
    tbl.push_back(mk(1'b0, 2'b01, Z, r2(0,20), N, 2'b01, N, Z, NORM, N, 2'b11, N, 2'b11, 2'b00));
    tbl.push_back(mk(1'b0, 2'b01, Z, r2(0,20), N, 2'b01, N, Z, NORM, N, N, N, 2'b11, 2'b00));
    // ID not ready: load not recorded
    tbl.push_back(mk(1'b0, 2'b01, Z, Z, N, N, 2'b01, r2(0,21), C_EX, N, N, N, 2'b11, 2'b00));
    tbl.push_back(mk(1'b0, 2'b10, r2(21,0), Z, 2'b10, N, N, Z, NORM, N, N, N, 2'b11, 2'b00));
    // stalled load is not recorded
    tbl.push_back(mk(1'b0, 2'b01, Z, Z, N, N, 2'b01, r2(0,22), NORM, N, N, N, 2'b11, 2'b00));
    tbl.push_back(mk(1'b0, 2'b01, r2(0,22), Z, 2'b01, N, 2'b01, r2(0,23), NORM, 2'b11, 2'b11, N, 2'b11, 2'b00));
    tbl.push_back(mk(1'b0, 2'b10, r2(23,0), Z, 2'b10, N, N, Z, NORM, N, N, N, 2'b11, 2'b00));
    // lane1 load while not issue-enabled is not recorded
    tbl.push_back(mk(1'b0, 2'b10, Z, Z, N, N, 2'b10, r2(24,0), NORM|C_PREV, N, N, N, 2'b01, 2'b00));
    tbl.push_back(mk(1'b0, 2'b10, r2(24,0), Z, 2'b10, N, N, Z, NORM, N, N, N, 2'b01, 2'b01));
    tbl.push_back(mk(1'b0, N, Z, Z, N, N, N, Z, NORM, N, N, N, 2'b11, 2'b00));

    foreach (tbl[i]) apply(tbl[i]);
    check_perf("table", t_s1, t_s2, t_k);

    // perf sequence: 10 stall cycles, 3 kill cycles, then reset
    hand.push_back(mk(1'b1, N, Z, Z, N, N, N, Z, NORM, N, N, N, N, N));
    hand.push_back(mk(1'b0, 2'b01, Z, Z, N, N, 2'b01, r2(0,5), NORM, N, N, N, 2'b11, 2'b00));
    for (int i = 0; i < 10; i++)
      hand.push_back(mk(1'b0, 2'b10, r2(5,0), Z, 2'b10, N, N, Z, C_ID, 2'b10, 2'b10, N, 2'b11, 2'b00));
    hand.push_back(mk(1'b0, N, Z, Z, N, N, N, Z, NORM|C_BR, N, N, 2'b11, 2'b11, 2'b00));
    hand.push_back(mk(1'b0, N, Z, Z, N, N, N, Z, NORM|C_BR, N, N, 2'b11, 2'b11, 2'b00));
    hand.push_back(mk(1'b0, N, Z, Z, N, N, N, Z, NORM|C_KILL, N, N, 2'b10, 2'b11, 2'b00));
    foreach (hand[i]) apply(hand[i]);
    check_perf("perf", 10, 10, 3);
    apply(mk(1'b1, N, Z, Z, N, N, N, Z, NORM|C_KILL, N, N, N, N, N));
    check_perf("perf_rst", 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
